// File: rtl/masked_state_sequencer.sv
// Share-separated state register with a built-in round sequencer for masked
// round-based ciphers: loads D0 once, then D1 for ROUNDS unstalled cycles.
module masked_state_sequencer #(
    parameter int WIDTH  = 64,
    parameter int SHARES = 3,
    parameter int ROUNDS = 31,
    localparam int RW    = $clog2(ROUNDS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [SHARES*WIDTH-1:0]   D0,
    input  logic [SHARES*WIDTH-1:0]   D1,
    output logic [SHARES*WIDTH-1:0]   Q,
    output logic                      sel,
    output logic                      last,
    output logic [RW-1:0]             round,
    output logic                      busy,
    output logic                      done
);

    // Control handshake: start is accepted only when not busy (IDLE or DONE);
    // busy covers every RUN cycle, done pulses for one cycle after the final
    // D1 load, and the two are never high together.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_t          state;
    logic [RW-1:0]   round_q;
    logic            load_d0;
    logic            load_d1;
    logic            final_load;

    always_comb begin
        load_d0    = 1'b0;
        load_d1    = 1'b0;
        final_load = 1'b0;
        if (state == IDLE || state == DONE) begin
            load_d0 = start;
        end
        if (state == RUN && !stall) begin
            load_d1    = 1'b1;
            final_load = (round_q == LAST_ROUND);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            round_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        round_q <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        round_q <= round_q + RW'(1);
                        if (final_load) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state   <= RUN;
                        round_q <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    round_q <= '0;
                end
            endcase
        end
    end

    // Each share owns an independent register slice; the two load strobes are
    // the only signals shared across shares, so no data bits ever mix.
    for (genvar i = 0; i < SHARES; i++) begin : g_share
        logic [WIDTH-1:0] share_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                share_q <= '0;
            end else if (load_d0) begin
                share_q <= D0[i*WIDTH +: WIDTH];
            end else if (load_d1) begin
                share_q <= D1[i*WIDTH +: WIDTH];
            end
        end

        assign Q[i*WIDTH +: WIDTH] = share_q;
    end

    assign sel   = load_d1;
    assign last  = final_load;
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign round = round_q;

endmodule

// File: tb/tb_masked_state_sequencer.sv
// Bench for masked_state_sequencer: cycle vector table with a post-edge
// scoreboard queue, plus a hand-written share-isolation run on a second instance.
module tb_masked_state_sequencer;

    localparam int N  = 12;
    localparam int NB = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [N-1:0]  d0 = '0;
    logic [N-1:0]  d1 = '0;
    logic [N-1:0]  q;
    logic          sel, last, busy, done;
    logic [1:0]    round;

    logic          rstb = 1'b1;
    logic          startb = 1'b0;
    logic          stallb = 1'b0;
    logic [NB-1:0] d0b = '0;
    logic [NB-1:0] d1b = '0;
    logic [NB-1:0] qb;
    logic          selb, lastb, busyb, doneb;
    logic [0:0]    roundb;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    masked_state_sequencer #(.WIDTH(4), .SHARES(3), .ROUNDS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .D0(d0), .D1(d1), .Q(q), .sel(sel), .last(last),
        .round(round), .busy(busy), .done(done)
    );

    masked_state_sequencer #(.WIDTH(8), .SHARES(3), .ROUNDS(1)) dut_iso (
        .clk(clk), .rst(rstb), .start(startb), .stall(stallb),
        .D0(d0b), .D1(d1b), .Q(qb), .sel(selb), .last(lastb),
        .round(roundb), .busy(busyb), .done(doneb)
    );

    typedef struct {
        logic          rst, start, stall;
        logic [N-1:0]  d0, d1;
        logic          pre;
        logic          sel, last;
        logic [N-1:0]  q;
        logic [1:0]    rnd;
        logic          busy, done;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic s, input logic st,
                                input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic pre, input logic esel, input logic elast,
                                input logic [N-1:0] eq, input logic [1:0] er,
                                input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.d0 = a; v.d1 = b;
        v.pre = pre; v.sel = esel; v.last = elast;
        v.q = eq; v.rnd = er; v.busy = eb; v.done = ed;
        vecs.push_back(v);
    endfunction

    function automatic logic [N-1:0] rnd12();
        return N'($urandom_range(0, 4095));
    endfunction

    task automatic apply(input vec_t v);
        logic [15:0] e;
        @(negedge clk);
        rst = v.rst; start = v.start; stall = v.stall; d0 = v.d0; d1 = v.d1;
        exp_q.push_back({v.q, v.rnd, v.busy, v.done});
        #1;
        if (v.pre) begin
            check("sel", {31'd0, sel}, {31'd0, v.sel});
            check("last", {31'd0, last}, {31'd0, v.last});
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("q", {20'd0, q}, {20'd0, e[15:4]});
        check("round", {30'd0, round}, {30'd0, e[3:2]});
        check("busy", {31'd0, busy}, {31'd0, e[1]});
        check("done", {31'd0, done}, {31'd0, e[0]});
    endtask

    task automatic step_iso(input logic s, input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input logic esel, input logic [NB-1:0] eq, input logic ed);
        @(negedge clk);
        rstb = 1'b0; startb = s; stallb = 1'b0; d0b = a; d1b = b;
        #1;
        check("iso_sel", {31'd0, selb}, {31'd0, esel});
        @(posedge clk);
        #1;
        check("iso_q", {8'd0, qb}, {8'd0, eq});
        check("iso_done", {31'd0, doneb}, {31'd0, ed});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] s0a, s0b;

        // 1: reset then idle with random data and stall noise
        add(1,0,0, rnd12(), rnd12(), 0,0,0, 12'h000,0,0,0);
        for (int i = 0; i < 5; i++)
            add(0,0,1'(i % 2), rnd12(), rnd12(), 1,0,0, 12'h000,0,0,0);

        // 2: basic run
        add(0,1,0, 12'h123, rnd12(), 1,0,0, 12'h123,0,1,0);
        add(0,0,0, rnd12(), 12'h456, 1,1,0, 12'h456,1,1,0);
        add(0,0,0, rnd12(), 12'h789, 1,1,0, 12'h789,2,1,0);
        add(0,0,0, rnd12(), 12'hABC, 1,1,1, 12'hABC,3,0,1);
        add(0,0,0, rnd12(), rnd12(), 1,0,0, 12'hABC,3,0,0);
        add(0,0,1, rnd12(), rnd12(), 1,0,0, 12'hABC,3,0,0);

        // 3: two stalled cycles after e1
        add(0,1,0, 12'h123, rnd12(), 1,0,0, 12'h123,0,1,0);
        add(0,0,0, rnd12(), 12'h456, 1,1,0, 12'h456,1,1,0);
        add(0,0,1, rnd12(), rnd12(), 1,0,0, 12'h456,1,1,0);
        add(0,1,1, rnd12(), rnd12(), 1,0,0, 12'h456,1,1,0);
        add(0,0,0, rnd12(), 12'h789, 1,1,0, 12'h789,2,1,0);
        add(0,0,0, rnd12(), 12'hABC, 1,1,1, 12'hABC,3,0,1);

        // 4: back-to-back start from DONE, start pulses during RUN ignored
        add(0,1,0, 12'hFFF, rnd12(), 1,0,0, 12'hFFF,0,1,0);
        add(0,1,0, rnd12(), 12'h111, 1,1,0, 12'h111,1,1,0);
        add(0,1,0, rnd12(), 12'h222, 1,1,0, 12'h222,2,1,0);
        add(0,0,0, rnd12(), 12'h333, 1,1,1, 12'h333,3,0,1);
        add(0,0,0, rnd12(), rnd12(), 1,0,0, 12'h333,3,0,0);

        // 5: reset mid-run, then a clean run
        add(0,1,0, 12'h123, rnd12(), 1,0,0, 12'h123,0,1,0);
        add(0,0,0, rnd12(), 12'h456, 1,1,0, 12'h456,1,1,0);
        add(1,1,0, rnd12(), 12'h789, 1,1,0, 12'h000,0,0,0);
        add(0,0,0, rnd12(), rnd12(), 1,0,0, 12'h000,0,0,0);
        add(0,1,0, 12'h5A5, rnd12(), 1,0,0, 12'h5A5,0,1,0);
        add(0,0,0, rnd12(), 12'h0A1, 1,1,0, 12'h0A1,1,1,0);
        add(0,0,0, rnd12(), 12'h0B2, 1,1,0, 12'h0B2,2,1,0);
        add(0,0,0, rnd12(), 12'h0C3, 1,1,1, 12'h0C3,3,0,1);
        add(0,0,0, rnd12(), rnd12(), 1,0,0, 12'h0C3,3,0,0);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i]);

        // 6: share isolation with ROUNDS=1
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("iso_reset_q", {8'd0, qb}, 32'd0);
        step_iso(1, 24'hA53C96, 24'h000000, 1'b0, 24'hA53C96, 1'b0);
        check("iso_last", {31'd0, lastb}, 32'd1);
        step_iso(0, 24'h000000, 24'h00FF00, 1'b1, 24'h00FF00, 1'b1);
        check("iso_round", {31'd0, roundb}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            s0a = 8'($urandom_range(0, 255));
            s0b = 8'($urandom_range(0, 255));
            step_iso(1, {8'h00, 8'hFF, s0a}, 24'h000000, 1'b0, {8'h00, 8'hFF, s0a}, 1'b0);
            step_iso(0, 24'h000000, {8'h00, 8'hFF, s0b}, 1'b1, {8'h00, 8'hFF, s0b}, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
